// File: rtl/decode_stage_hz.sv
// decode_stage_hz
// Decode stage of the pipelined RISC core: architectural register file with a
// write-through write-back port, opcode decoder, load-use hazard detection and
// the ID/EX pipeline register. Two-word LDM (load immediate) is sequenced by a
// small FSM that captures the destination from the first word and the
// immediate from the second.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   if_valid          fetch presents a word on instruction
//   instruction       fetched word
//   flush             kill decode contents (branch taken in EX)
//   wb_reg_write      write-back enable, with wb_addr / wb_data
//   stall             fetch must hold its current word (combinational)
//   ex_*              ID/EX pipeline register outputs
//
// FSM states
//   state    | meaning
//   IDLE     | decoding ordinary instructions
//   WAIT_IMM | LDM seen, next valid word is its immediate

module decode_stage_hz #(
    parameter int WIDTH      = 16,
    parameter int N_REGS     = 8,
    parameter int INST_WIDTH = 16,
    localparam int REG_AW    = $clog2(N_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    input  logic [INST_WIDTH-1:0] instruction,
    input  logic                  flush,
    input  logic                  wb_reg_write,
    input  logic [REG_AW-1:0]     wb_addr,
    input  logic [WIDTH-1:0]      wb_data,
    output logic                  stall,
    output logic                  ex_valid,
    output logic [2:0]            ex_alu_op,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_alu_src_imm,
    output logic [REG_AW-1:0]     ex_rd,
    output logic [REG_AW-1:0]     ex_rs1,
    output logic [REG_AW-1:0]     ex_rs2,
    output logic [WIDTH-1:0]      ex_rdata1,
    output logic [WIDTH-1:0]      ex_rdata2,
    output logic [WIDTH-1:0]      ex_imm
);

    localparam logic [4:0] OP_LDD = 5'd8;
    localparam logic [4:0] OP_STD = 5'd9;
    localparam logic [4:0] OP_LDM = 5'd10;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_IMM = 1'b1
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [2:0]        alu_op;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              alu_src_imm;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [WIDTH-1:0]  rdata1;
        logic [WIDTH-1:0]  rdata2;
        logic [WIDTH-1:0]  imm;
    } idex_t;

    state_t            state_q, state_d;
    logic [REG_AW-1:0] ldm_rd_q, ldm_rd_d;
    idex_t             idex_q, idex_d, dec;

    logic [WIDTH-1:0]  regs [N_REGS];
    logic [WIDTH-1:0]  rd1, rd2, imm_sext;
    logic [4:0]        opcode;
    logic [REG_AW-1:0] f_rd, f_rs1, f_rs2;
    logic              uses_rs1, uses_rs2, is_ldm, hazard;

    assign opcode   = instruction[INST_WIDTH-1 -: 5];
    assign f_rd     = instruction[INST_WIDTH-6 -: REG_AW];
    assign f_rs1    = instruction[INST_WIDTH-6-REG_AW -: REG_AW];
    assign f_rs2    = instruction[INST_WIDTH-6-2*REG_AW -: REG_AW];
    assign imm_sext = WIDTH'($signed(instruction));

    // Register file; a same-cycle write-back is forwarded to the read ports.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
        end else if (wb_reg_write) begin
            regs[wb_addr] <= wb_data;
        end
    end

    assign rd1 = (wb_reg_write && wb_addr == f_rs1) ? wb_data : regs[f_rs1];
    assign rd2 = (wb_reg_write && wb_addr == f_rs2) ? wb_data : regs[f_rs2];

    always_comb begin
        dec        = '0;
        uses_rs1   = 1'b0;
        uses_rs2   = 1'b0;
        is_ldm     = 1'b0;
        dec.valid  = 1'b1;
        dec.rd     = f_rd;
        dec.rs1    = f_rs1;
        dec.rs2    = f_rs2;
        dec.rdata1 = rd1;
        dec.rdata2 = rd2;
        dec.imm    = imm_sext;
        if (opcode >= 5'd1 && opcode <= 5'd7) begin
            dec.alu_op    = opcode[2:0];
            dec.reg_write = 1'b1;
            uses_rs1      = 1'b1;
            uses_rs2      = 1'b1;
        end else if (opcode == OP_LDD) begin
            dec.mem_read   = 1'b1;
            dec.mem_to_reg = 1'b1;
            dec.reg_write  = 1'b1;
            uses_rs1       = 1'b1;
        end else if (opcode == OP_STD) begin
            dec.mem_write = 1'b1;
            uses_rs1      = 1'b1;
            uses_rs2      = 1'b1;
        end else if (opcode == OP_LDM) begin
            is_ldm = 1'b1;
        end
    end

    // Hazard only exists in IDLE: the LDM immediate word is never decoded.
    assign hazard = (state_q == IDLE) && if_valid && idex_q.valid && idex_q.mem_read &&
                    ((uses_rs1 && idex_q.rd == f_rs1) || (uses_rs2 && idex_q.rd == f_rs2));
    assign stall  = hazard && !flush;

    always_comb begin
        state_d  = state_q;
        ldm_rd_d = ldm_rd_q;
        idex_d   = '0;
        if (flush) begin
            state_d  = IDLE;
            ldm_rd_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (if_valid) begin
                        if (is_ldm) begin
                            ldm_rd_d = f_rd;
                            state_d  = WAIT_IMM;
                        end else if (!hazard) begin
                            idex_d = dec;
                        end
                    end
                end
                WAIT_IMM: begin
                    if (if_valid) begin
                        idex_d.valid       = 1'b1;
                        idex_d.rd          = ldm_rd_q;
                        idex_d.reg_write   = 1'b1;
                        idex_d.alu_src_imm = 1'b1;
                        idex_d.imm         = imm_sext;
                        state_d            = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            ldm_rd_q <= '0;
            idex_q   <= '0;
        end else begin
            state_q  <= state_d;
            ldm_rd_q <= ldm_rd_d;
            idex_q   <= idex_d;
        end
    end

    assign ex_valid       = idex_q.valid;
    assign ex_alu_op      = idex_q.alu_op;
    assign ex_reg_write   = idex_q.reg_write;
    assign ex_mem_read    = idex_q.mem_read;
    assign ex_mem_write   = idex_q.mem_write;
    assign ex_mem_to_reg  = idex_q.mem_to_reg;
    assign ex_alu_src_imm = idex_q.alu_src_imm;
    assign ex_rd          = idex_q.rd;
    assign ex_rs1         = idex_q.rs1;
    assign ex_rs2         = idex_q.rs2;
    assign ex_rdata1      = idex_q.rdata1;
    assign ex_rdata2      = idex_q.rdata2;
    assign ex_imm         = idex_q.imm;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Self-checking bench for decode_stage_hz: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the stage.

module tb_decode_stage_hz;

    localparam int WIDTH      = 16;
    localparam int N_REGS     = 8;
    localparam int INST_WIDTH = 16;
    localparam int REG_AW     = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              if_valid = 1'b0;
    logic [15:0]       instruction = '0;
    logic              flush = 1'b0;
    logic              wb_reg_write = 1'b0;
    logic [REG_AW-1:0] wb_addr = '0;
    logic [15:0]       wb_data = '0;
    logic              stall, ex_valid;
    logic [2:0]        ex_alu_op;
    logic              ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src_imm;
    logic [REG_AW-1:0] ex_rd, ex_rs1, ex_rs2;
    logic [15:0]       ex_rdata1, ex_rdata2, ex_imm;

    always #5 clk = ~clk;

    decode_stage_hz #(.WIDTH(WIDTH), .N_REGS(N_REGS), .INST_WIDTH(INST_WIDTH)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .instruction(instruction),
        .flush(flush), .wb_reg_write(wb_reg_write), .wb_addr(wb_addr), .wb_data(wb_data),
        .stall(stall), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src_imm(ex_alu_src_imm),
        .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model. m_kind: 0 = bubble, 1 = decoded instruction, 2 = LDM issue.
    int m_regs [N_REGS];
    int m_kind, m_alu, m_rw, m_mr, m_mw, m_mtr, m_asi;
    int m_rd, m_rs1, m_rs2, m_d1, m_d2, m_imm;
    bit m_wait;
    int m_ldm_rd;
    bit last_stall;

    function automatic logic [15:0] enc(input int opc, input int rd, input int rs1, input int rs2);
        return 16'((opc << 11) | (rd << 8) | (rs1 << 5) | (rs2 << 2));
    endfunction

    task automatic model_reset();
        foreach (m_regs[i]) m_regs[i] = 0;
        m_kind = 0; m_alu = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_mtr = 0; m_asi = 0;
        m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_d1 = 0; m_d2 = 0; m_imm = 0;
        m_wait = 0; m_ldm_rd = 0; last_stall = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check_val("rst_valid", 32'(ex_valid), 0);
        check_val("rst_ctrl", 32'({ex_alu_op, ex_reg_write, ex_mem_read, ex_mem_write,
                                    ex_mem_to_reg, ex_alu_src_imm}), 0);
        check_val("rst_regs", 32'({ex_rd, ex_rs1, ex_rs2}), 0);
        check_val("rst_data", 32'({ex_rdata1, ex_rdata2}), 0);
        check_val("rst_imm", 32'(ex_imm), 0);
        check_val("rst_stall", 32'(stall), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // One clock: drive inputs, check stall, let the edge happen, check ID/EX.
    task automatic cycle(input bit v, input logic [15:0] w, input bit fl,
                         input bit we, input int wa, input int wd);
        int opc, rd, rs1, rs2, d1, d2;
        bit u1, u2, haz;
        int n_kind, n_alu, n_rw, n_mr, n_mw, n_mtr, n_asi, n_rd, n_rs1, n_rs2, n_d1, n_d2, n_imm;
        if_valid     = v;
        instruction  = w;
        flush        = fl;
        wb_reg_write = we;
        wb_addr      = REG_AW'(wa);
        wb_data      = 16'(wd);
        opc = int'(w) / 2048;
        rd  = (int'(w) / 256) % 8;
        rs1 = (int'(w) / 32) % 8;
        rs2 = (int'(w) / 4) % 8;
        d1  = (we && wa == rs1) ? wd : m_regs[rs1];
        d2  = (we && wa == rs2) ? wd : m_regs[rs2];
        u1  = (opc >= 1 && opc <= 9);
        u2  = (opc >= 1 && opc <= 7) || opc == 9;
        haz = !m_wait && v && m_kind != 0 && m_mr != 0 &&
              ((u1 && m_rd == rs1) || (u2 && m_rd == rs2));
        #1;
        check_val("stall", 32'(stall), 32'(haz && !fl));
        last_stall = haz && !fl;

        n_kind = 0; n_alu = 0; n_rw = 0; n_mr = 0; n_mw = 0; n_mtr = 0; n_asi = 0;
        n_rd = 0; n_rs1 = 0; n_rs2 = 0; n_d1 = 0; n_d2 = 0; n_imm = 0;
        if (fl) begin
            m_wait = 0;
        end else if (m_wait) begin
            if (v) begin
                n_kind = 2; n_rd = m_ldm_rd; n_imm = int'(w); n_rw = 1; n_asi = 1;
                m_wait = 0;
            end
        end else if (v) begin
            if (opc == 10) begin
                m_wait = 1; m_ldm_rd = rd;
            end else if (!haz) begin
                n_kind = 1; n_rd = rd; n_rs1 = rs1; n_rs2 = rs2;
                n_d1 = d1; n_d2 = d2; n_imm = int'(w);
                n_alu = (opc >= 1 && opc <= 7) ? opc : 0;
                n_rw  = (opc >= 1 && opc <= 8) ? 1 : 0;
                n_mr  = (opc == 8) ? 1 : 0;
                n_mtr = (opc == 8) ? 1 : 0;
                n_mw  = (opc == 9) ? 1 : 0;
            end
        end

        @(posedge clk);
        if (we) m_regs[wa] = wd;
        m_kind = n_kind; m_alu = n_alu; m_rw = n_rw; m_mr = n_mr; m_mw = n_mw;
        m_mtr = n_mtr; m_asi = n_asi; m_rd = n_rd; m_rs1 = n_rs1; m_rs2 = n_rs2;
        m_d1 = n_d1; m_d2 = n_d2; m_imm = n_imm;
        #1;
        check_val("ex_valid", 32'(ex_valid), 32'(m_kind != 0));
        check_val("ex_alu_op", 32'(ex_alu_op), 32'(m_alu));
        check_val("ex_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src_imm}),
                  32'((m_rw << 4) | (m_mr << 3) | (m_mw << 2) | (m_mtr << 1) | m_asi));
        if (m_kind != 0) begin
            check_val("ex_rd", 32'(ex_rd), 32'(m_rd));
            check_val("ex_imm", 32'(ex_imm), 32'(m_imm));
        end
        if (m_kind == 1) begin
            check_val("ex_rs1", 32'(ex_rs1), 32'(m_rs1));
            check_val("ex_rs2", 32'(ex_rs2), 32'(m_rs2));
            check_val("ex_rdata1", 32'(ex_rdata1), 32'(m_d1));
            check_val("ex_rdata2", 32'(ex_rdata2), 32'(m_d2));
        end
    endtask

    initial begin
        logic [15:0] w;
        bit v, fl, we;
        model_reset();
        #12;
        do_reset();

        // write-through feeding an ADD
        cycle(1, enc(1, 1, 2, 2), 0, 1, 2, 16'h00AB);
        // load-use: LDD r4 <- [r1], then ADD using r4 stalls once
        cycle(1, enc(8, 4, 1, 0), 0, 0, 0, 0);
        cycle(1, enc(1, 3, 4, 2), 0, 0, 0, 0);
        cycle(1, enc(1, 3, 4, 2), 0, 0, 0, 0);
        // STD hazard on rs2
        cycle(1, enc(8, 6, 1, 0), 0, 1, 6, 16'h1234);
        cycle(1, enc(9, 0, 2, 6), 0, 0, 0, 0);
        cycle(1, enc(9, 0, 2, 6), 0, 0, 0, 0);
        // LDM r5, 0xFFF0
        cycle(1, enc(10, 5, 0, 0), 0, 0, 0, 0);
        cycle(1, 16'hFFF0, 0, 0, 0, 0);
        // LDM with gaps, then flush discards it
        cycle(1, enc(10, 5, 0, 0), 0, 0, 0, 0);
        cycle(0, 16'h0000, 0, 0, 0, 0);
        cycle(0, 16'h0000, 0, 0, 0, 0);
        cycle(1, 16'h1234, 1, 0, 0, 0);
        cycle(1, 16'h0800, 0, 0, 0, 0);
        cycle(1, enc(8, 2, 3, 0), 0, 0, 0, 0);
        // flush during a load-use hazard
        cycle(1, enc(8, 4, 1, 0), 0, 0, 0, 0);
        cycle(1, enc(2, 3, 4, 4), 1, 1, 5, 16'h7777);
        cycle(1, enc(2, 3, 4, 5), 0, 0, 0, 0);
        // LDM immediate word that looks like a hazarding instruction
        cycle(1, enc(8, 1, 0, 0), 0, 0, 0, 0);
        cycle(1, enc(10, 7, 0, 0), 0, 0, 0, 0);
        cycle(1, enc(1, 2, 1, 1), 0, 0, 0, 0);

        // mid-operation resets, including in the middle of an LDM
        cycle(1, enc(3, 2, 0, 1), 0, 1, 3, 16'h5555);
        do_reset();
        cycle(1, enc(10, 2, 0, 0), 0, 0, 0, 0);
        do_reset();
        cycle(1, 16'hFFF0, 0, 0, 0, 0);
        cycle(1, enc(1, 1, 3, 3), 0, 0, 0, 0);

        // randomized traffic
        w = '0;
        for (int i = 0; i < 600; i++) begin
            if (last_stall) begin
                v = 1;
            end else begin
                v = ($urandom_range(0, 4) != 0);
                if ($urandom_range(0, 7) == 0)
                    w = 16'($urandom);
                else
                    w = enc($urandom_range(0, 12), $urandom_range(0, 3), $urandom_range(0, 3),
                            $urandom_range(0, 3)) | 16'($urandom_range(0, 3));
            end
            fl = ($urandom_range(0, 11) == 0);
            we = $urandom_range(0, 1) == 1;
            cycle(v, w, fl, we, $urandom_range(0, 7), $urandom_range(0, 65535));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
